// File: rtl/lpf_coef_ctrl.sv
//------------------------------------------------------------------------------
// Module   : lpf_coef_ctrl
// Brief    : MIDI cutoff CC -> ROM-fetched biquad coefficient set, double-banked
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif
`ifndef MIDI_CMD_CC
`define MIDI_CMD_CC 3'd3
`endif

module lpf_coef_ctrl #(
  parameter int          CUTOFF_CC = 74,
  parameter int          MIDI_CH   = 0,
  parameter int          NUM_COEFS = 5,
  parameter logic [17:0] RST_B0    = 18'h10000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      midi_rdy,
  input  logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]                midi_ch_sysn,
  input  logic [6:0]                midi_data0,
  input  logic [6:0]                midi_data1,
  input  logic                      lpf_idle,
  output logic [9:0]                rom_addr,
  input  logic signed [17:0]        rom_data,
  input  logic [2:0]                coef_rd_idx,
  output logic signed [17:0]        coef_rd_data,
  output logic                      coef_busy,
  output logic                      coef_updated,
  output logic [6:0]                cutoff_active
);

  localparam logic [2:0] c_LAST_IDX = 3'(NUM_COEFS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_WAIT_LAST = 2'd2,
    ST_PENDING   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_bank_sel;
  logic signed [17:0] r_bank [0:1][0:NUM_COEFS-1];
  logic [6:0]         r_cutoff_req;
  logic [6:0]         r_cutoff_fetch;
  logic [2:0]         r_idx;
  logic [2:0]         r_idx_d;
  logic               r_fetch_d;
  logic               r_reload;
  logic [9:0]         r_rom_addr;
  logic               r_coef_updated;
  logic [6:0]         r_cutoff_active;

  logic               w_cc_event;
  logic [6:0]         w_cutoff_new;
  logic               w_start;
  logic               w_swap;
  logic               w_reload_set;
  logic               w_reload_clr;

  assign w_cc_event = midi_rdy && (midi_cmd == `MIDI_CMD_CC) &&
                      (midi_ch_sysn == 4'(MIDI_CH)) && (midi_data0 == 7'(CUTOFF_CC));
  // A fetch started on the same cycle as a CC must use that CC's value.
  assign w_cutoff_new = w_cc_event ? midi_data1 : r_cutoff_req;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_swap       = 1'b0;
    w_reload_set = 1'b0;
    w_reload_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cc_event) begin
          w_start      = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_reload_set = w_cc_event;
        if (r_idx == c_LAST_IDX) w_state_next = ST_WAIT_LAST;
      end
      ST_WAIT_LAST: begin
        if (r_reload || w_cc_event) begin
          w_start      = 1'b1;
          w_reload_clr = 1'b1;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_cc_event) begin
          w_start      = 1'b1;
          w_state_next = ST_FETCH;
        end else if (lpf_idle) begin
          w_swap       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_bank_sel      <= 1'b0;
      r_cutoff_req    <= 7'd0;
      r_cutoff_fetch  <= 7'd0;
      r_idx           <= 3'd0;
      r_idx_d         <= 3'd0;
      r_fetch_d       <= 1'b0;
      r_reload        <= 1'b0;
      r_rom_addr      <= 10'd0;
      r_coef_updated  <= 1'b0;
      r_cutoff_active <= 7'd127;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_COEFS; i++) begin
          r_bank[b][i] <= (i == 0) ? RST_B0 : 18'sd0;
        end
      end
    end else begin
      r_state        <= w_state_next;
      r_coef_updated <= w_swap;
      r_fetch_d      <= (r_state == ST_FETCH);
      r_idx_d        <= r_idx;
      if (w_cc_event) r_cutoff_req <= midi_data1;

      if (w_reload_clr)      r_reload <= 1'b0;
      else if (w_reload_set) r_reload <= 1'b1;

      if (w_start) begin
        r_cutoff_fetch <= w_cutoff_new;
        r_idx          <= 3'd0;
        r_rom_addr     <= {w_cutoff_new, 3'd0};
      end else if ((r_state == ST_FETCH) && (r_idx != c_LAST_IDX)) begin
        r_idx      <= r_idx + 3'd1;
        r_rom_addr <= {r_cutoff_fetch, r_idx + 3'd1};
      end

      // ROM word for the address issued last cycle lands in the shadow bank.
      if (r_fetch_d) r_bank[~r_bank_sel][r_idx_d] <= rom_data;

      if (w_swap) begin
        r_bank_sel      <= ~r_bank_sel;
        r_cutoff_active <= r_cutoff_fetch;
      end
    end
  end

  assign coef_rd_data  = (coef_rd_idx <= c_LAST_IDX) ? r_bank[r_bank_sel][coef_rd_idx] : 18'sd0;
  assign rom_addr      = r_rom_addr;
  assign coef_busy     = (r_state != ST_IDLE);
  assign coef_updated  = r_coef_updated;
  assign cutoff_active = r_cutoff_active;

endmodule

`default_nettype wire
